// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; kept at least 1 bit so the counter always exists.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_div_ctrl_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = seq_div_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             unused_diff_msb;

  assign shifted = {rem_i, bit_i};
  // Carry out of (P' + ~D + 1) is the inverse of the borrow.
  assign sum     = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_i}} + (WIDTH+2)'(1);
  assign qbit_o  = sum[WIDTH+1];
  // A non-negative difference is below the divisor, so its top bit is always zero.
  assign rem_o   = qbit_o ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_diff_msb = sum[WIDTH];

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle unsigned restoring divider controller with start/done handshake.
// Optional abort input enabled by defining SEQ_DIV_ABORT_EN.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_DIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             abort_w;

`ifdef SEQ_DIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (p_q),
    .bit_i     (sh_q[WIDTH-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    sh_d    = sh_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ITER;
            div_d   = divisor;
            p_d     = '0;
            sh_d    = dividend;
            count_d = '0;
          end
        end
      end
      ITER: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          p_d     = step_rem;
          sh_d    = {sh_q[WIDTH-2:0], step_qbit};
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH-1)) begin
            state_d = DONE;
            quot_d  = {sh_q[WIDTH-2:0], step_qbit};
            rem_d   = step_rem;
            dbz_d   = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      p_q     <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == ITER);
      // done is registered from DONE, so it trails the result load by one edge.
      done_q  <= (state_q == DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed, table-driven bench for seq_div_ctrl at WIDTH=4.
module tb_seq_div_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
`ifdef SEQ_DIV_ABORT_EN
  logic         abort;
`endif

  int errors = 0;
  int checks = 0;

  seq_div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SEQ_DIV_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until done and busy samples on the way.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output int lat, output int busy_cnt);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 'x;
    divisor  = 'x;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic check_outputs(input string tag, input int q, input int r, input int dbz);
    check({tag, " quotient"}, quotient, q);
    check({tag, " remainder"}, remainder, r);
    check({tag, " div_by_zero"}, div_by_zero, dbz);
  endtask

  initial begin
    int lat, bc;

    vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dbz: 1'b0, lat: 5, busy_cycles: 4};
    vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0, lat: 5, busy_cycles: 4};
    vecs[2] = '{dd: 4'd2,  dv: 4'd9,  q: 4'd0,  r: 4'd2, dbz: 1'b0, lat: 5, busy_cycles: 4};
    vecs[3] = '{dd: 4'd7,  dv: 4'd0,  q: 4'd15, r: 4'd7, dbz: 1'b1, lat: 1, busy_cycles: 0};
    vecs[4] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0, lat: 5, busy_cycles: 4};
    vecs[5] = '{dd: 4'd0,  dv: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0, lat: 5, busy_cycles: 4};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV_ABORT_EN
    abort    = 1'b0;
`endif
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check_outputs("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, lat, bc);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy cycles", i), bc, vecs[i].busy_cycles);
      check($sformatf("v%0d busy at done", i), busy, 0);
      check_outputs($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz);
      tick();
      check($sformatf("v%0d done single pulse", i), done, 0);
      check($sformatf("v%0d quotient held", i), quotient, vecs[i].q);
    end

    // 12/5 with a 9/2 start pulsed mid-operation, then a start on the done cycle.
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("busy-ignore latency", lat, 5);
    check_outputs("busy-ignore 12/5", 2, 2, 0);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("start on done cycle ignored busy", busy, 0);
    check("start on done cycle ignored done", done, 0);
    run_div(4'd9, 4'd2, lat, bc);
    check("9/2 latency", lat, 5);
    check_outputs("9/2", 4, 1, 0);
    tick();

    // Reset during the second ITER cycle of 11/3.
    dividend = 4'd11;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check_outputs("mid reset", 0, 0, 0);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) bc++;
      tick();
    end
    check("no done after reset", bc, 0);
    run_div(4'd11, 4'd3, lat, bc);
    check("11/3 latency", lat, 5);
    check_outputs("11/3", 3, 2, 0);
    tick();

`ifdef SEQ_DIV_ABORT_EN
    // Abort on the third ITER cycle of 14/4; prior 11/3 result must survive.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check_outputs("abort held", 3, 2, 0);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) bc++;
      tick();
    end
    check("no done after abort", bc, 0);
    run_div(4'd14, 4'd4, lat, bc);
    check_outputs("14/4", 3, 2, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
